sensor_paddle_map: RTL
======================

# sensor_paddle_map

Converts ultrasonic echo pulse widths, measured in clock cycles by the sensor driver, into a paddle vertical position for the PONG game logic. Each accepted measurement is clamped, divided by a fixed cycles-per-pixel factor with a multi-cycle restoring divider, limited to the playfield, and optionally smoothed. A watchdog flags a lost or disconnected sensor. The block sits between the sensor driver and the paddle/game-state logic.

## Interface
- ECHO_MIN, 11_600: echo width in cycles mapped to y = 0 (2 cm at 100 MHz).
- CYC_PER_PX, 1_450: echo cycles per paddle pixel.
- Y_MAX, 672: largest paddle_y (768 lines minus 96-line paddle).
- DIV_W, 20: dividend/quotient width; the divider runs DIV_W cycles.
- TIMEOUT, 20_000_000: cycles without an accepted sample before a fault is flagged (200 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- btnC  in  1  reset; one clock, synchronous, active-high.
- echo_time  in  33  measured echo width in cycles.
- echo_valid  in  1  single-cycle strobe; echo_time is valid in the same cycle.
- paddle_y  out  12  paddle top-edge position, 0..Y_MAX.
- paddle_valid  out  1  one-cycle pulse when paddle_y updates.
- busy  out  1  high while a sample is in flight.
- sensor_fault  out  1  high after TIMEOUT cycles without an accepted sample.

## Operation
- States: IDLE, CLAMP, DIV, FILT (only with the filter compiled in).
- A sample is accepted in IDLE when echo_valid=1 and echo_time≠0. echo_time is latched and the block moves to CLAMP.
- echo_valid while busy=1 is ignored, with no queueing. echo_time=0 is never accepted and does not reset the watchdog.
- CLAMP: d = 0 if echo_time < ECHO_MIN. Otherwise d = echo_time − ECHO_MIN, saturated to 2^DIV_W−1.
- DIV: restoring division d / CYC_PER_PX, one quotient bit per cycle, MSB first, exactly DIV_W cycles. The remainder is discarded (truncation). The quotient q is then clamped to Y_MAX.
- FILT: 4-entry sample history.
  - When not primed: all 4 entries are set to q, the block becomes primed, and the result is q.
  - When primed: the oldest entry is shifted out, q is shifted in, and the result is the 14-bit sum of the 4 entries >> 2 (floor).
- On leaving the last state, paddle_y is loaded with the result, paddle_valid pulses, and the block returns to IDLE.
- Watchdog: a counter is cleared on every accepted sample and otherwise increments, saturating.
  - When it reaches TIMEOUT, sensor_fault is set, paddle_y is held, and the filter is unprimed.
  - The next accepted sample clears sensor_fault when its paddle_valid is issued.
- Reset values: paddle_y = Y_MAX/2 (336), paddle_valid = 0, busy = 0, sensor_fault = 0, state IDLE, watchdog 0, filter unprimed.
- Reset mid-operation: the in-flight sample is discarded and no paddle_valid is issued.

## Timing
- echo_valid is sampled in cycle 0. busy is high from cycle 1 through cycle DIV_W+2, covering CLAMP in cycle 1, DIV in cycles 2..DIV_W+1, and FILT in cycle DIV_W+2.
- paddle_valid is high in cycle DIV_W+3 (23 with defaults); paddle_y carries the new value from that cycle on.
- The block is back in IDLE in cycle DIV_W+3, so an echo_valid in that cycle is accepted.
- Without the filter, FILT is skipped: busy covers cycles 1..DIV_W+1 and paddle_valid arrives in cycle DIV_W+2 (22).
- sensor_fault rises exactly TIMEOUT cycles after the last accepted echo_valid, or after reset release if no sample has been accepted.
- Simultaneous timeout expiry and accepted sample: the sample wins; the watchdog clears and the fault does not assert.

## Configuration
- SENSOR_FILTER_EN defined: the FILT state and 4-tap moving average are present, with latency DIV_W+3.
- SENSOR_FILTER_EN undefined: paddle_y = clamped q directly, the FILT state and history registers are absent, and latency is DIV_W+2. Unpriming on fault has no effect.

## Test plan
- Reset: btnC=1 for 2 cycles, then 0 -> paddle_y=336, paddle_valid=0, busy=0, sensor_fault=0.
- Single sample after reset: echo_time=156_600 (q=100) -> paddle_valid in cycle 23, paddle_y=100.
- Filter ramp (SENSOR_FILTER_EN): primed at 100, then four samples of 301_600 (q=200) -> paddle_y = 125, 150, 175, 200.
- Range limits: echo_time=5_000 -> paddle_y=0. After reset, echo_time=2_000_000 saturates d to 1_048_575, q=723 -> paddle_y=672.
- Rejection and mid-operation reset:
  - echo_valid in cycle 5 of a conversion is ignored, giving exactly one paddle_valid.
  - echo_time=0 gives no busy and no output.
  - btnC during DIV gives busy=0 the next cycle and no paddle_valid.
- Watchdog: no accepted sample for 20_000_000 cycles -> sensor_fault=1 and paddle_y unchanged. A following echo_time=156_600 -> sensor_fault=0 with paddle_valid, paddle_y=100 (filter re-primed).

Source files
------------

// File: rtl/sensor_paddle_map.sv
// rtl/sensor_paddle_map.sv - ultrasonic echo width to PONG paddle position
//
// Purpose:
//   Converts an echo pulse width (in clock cycles) into a paddle top-edge
//   row. Each accepted sample is offset by ECHO_MIN, saturated to the
//   divider width, divided by CYC_PER_PX with a one-bit-per-cycle restoring
//   divider, limited to Y_MAX and optionally smoothed by a 4-tap moving
//   average. A watchdog raises sensor_fault when no sample has been accepted
//   for TIMEOUT cycles.
//
// Optional feature macro: SENSOR_FILTER_EN
//   defined   -> FILT state plus 4-entry history, latency DIV_W+3
//   undefined -> quotient goes straight to paddle_y, latency DIV_W+2
//
// Ports:
//   clk           in   1   system clock
//   btnC          in   1   synchronous active-high reset
//   echo_time     in  33   measured echo width in cycles
//   echo_valid    in   1   single-cycle strobe qualifying echo_time
//   paddle_y      out 12   paddle top-edge row, 0..Y_MAX
//   paddle_valid  out  1   one-cycle pulse when paddle_y updates
//   busy          out  1   a sample is being converted
//   sensor_fault  out  1   no accepted sample for TIMEOUT cycles

module sensor_paddle_map #(
  parameter int unsigned ECHO_MIN   = 11_600,
  parameter int unsigned CYC_PER_PX = 1_450,
  parameter int unsigned Y_MAX      = 672,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned TIMEOUT    = 20_000_000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [32:0] echo_time,
  input  logic        echo_valid,
  output logic [11:0] paddle_y,
  output logic        paddle_valid,
  output logic        busy,
  output logic        sensor_fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLAMP = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
`ifdef SENSOR_FILTER_EN
  localparam logic [1:0] S_FILT  = 2'd3;
`endif

  // Remainder always stays below the divisor, so it needs only REM_W bits;
  // the shifted trial value needs one more.
  localparam int unsigned REM_W = $clog2(CYC_PER_PX);
  localparam int unsigned CNT_W = $clog2(DIV_W);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  localparam logic [32:0]      ECHO_MIN_W = 33'(ECHO_MIN);
  localparam logic [32:0]      D_SAT      = 33'((34'd1 << DIV_W) - 34'd1);
  localparam logic [REM_W:0]   DIVISOR    = (REM_W + 1)'(CYC_PER_PX);
  localparam logic [DIV_W-1:0] Y_MAX_Q    = DIV_W'(Y_MAX);
  localparam logic [11:0]      Y_MAX_Y    = 12'(Y_MAX);
  localparam logic [11:0]      Y_MID      = 12'(Y_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV_W - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ARM     = WD_W'(TIMEOUT - 2);

  logic [1:0]       state_q, state_d;
  logic [32:0]      echo_q,  echo_d;
  logic [DIV_W-1:0] dvd_q,   dvd_d;    // dividend shifts out, quotient shifts in
  logic [REM_W-1:0] rem_q,   rem_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WD_W-1:0]  wd_q,    wd_d;
  logic [11:0]      y_q,     y_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;

`ifdef SENSOR_FILTER_EN
  logic [11:0] hist_q [4];             // [0] newest .. [3] oldest
  logic [11:0] hist_d [4];
  logic        primed_q, primed_d;
  logic [11:0] q_lim;
  logic [13:0] hist_sum;
`endif

  logic             accept;
  logic [32:0]      echo_diff;
  logic [DIV_W-1:0] d_clamp;
  logic [REM_W:0]   rem_sh;
  logic             q_bit;
  logic [REM_W-1:0] rem_next;
  logic [DIV_W-1:0] quot_next;
  logic             wd_expire;

  function automatic logic [11:0] clamp_y(input logic [DIV_W-1:0] q);
    return (q > Y_MAX_Q) ? Y_MAX_Y : q[11:0];
  endfunction

  // Datapath helpers shared by the state machine.
  always_comb begin
    accept = (state_q == S_IDLE) && echo_valid && (echo_time != 33'd0);

    echo_diff = echo_q - ECHO_MIN_W;
    if (echo_q < ECHO_MIN_W) begin
      d_clamp = '0;
    end else if (echo_diff > D_SAT) begin
      d_clamp = '1;
    end else begin
      d_clamp = echo_diff[DIV_W-1:0];
    end

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    rem_sh    = {rem_q, dvd_q[DIV_W-1]};
    q_bit     = (rem_sh >= DIVISOR);
    rem_next  = q_bit ? REM_W'(rem_sh - DIVISOR) : rem_sh[REM_W-1:0];
    quot_next = {dvd_q[DIV_W-2:0], q_bit};

    // wd_q counts edges since the last accept (or reset). Arming on TIMEOUT-2
    // makes the fault visible exactly TIMEOUT cycles after the accepting cycle;
    // an accept in that same cycle clears the count and suppresses the fault.
    wd_expire = !accept && (wd_q == WD_ARM);
  end

  always_comb begin
    state_d = state_q;
    echo_d  = echo_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    valid_d = 1'b0;
    fault_d = fault_q;
`ifdef SENSOR_FILTER_EN
    hist_d   = hist_q;
    primed_d = primed_q;
    q_lim    = clamp_y(dvd_q);
    hist_sum = 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]) + 14'(q_lim);
`endif

    if (accept) begin
      wd_d = '0;
    end else if (wd_q != WD_LAST) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          echo_d  = echo_time;
          state_d = S_CLAMP;
        end
      end
      S_CLAMP: begin
        dvd_d   = d_clamp;
        rem_d   = '0;
        cnt_d   = CNT_LAST;
        state_d = S_DIV;
      end
      S_DIV: begin
        dvd_d = quot_next;
        rem_d = rem_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
`ifdef SENSOR_FILTER_EN
          state_d = S_FILT;
`else
          state_d = S_IDLE;
          y_d     = clamp_y(quot_next);
          valid_d = 1'b1;
          fault_d = 1'b0;
`endif
        end
      end
`ifdef SENSOR_FILTER_EN
      S_FILT: begin
        if (!primed_q) begin
          // First sample after reset or a fault fills the whole history so
          // the average starts from the real position, not from zero.
          for (int i = 0; i < 4; i++) begin
            hist_d[i] = q_lim;
          end
          primed_d = 1'b1;
          y_d      = q_lim;
        end else begin
          hist_d[3] = hist_q[2];
          hist_d[2] = hist_q[1];
          hist_d[1] = hist_q[0];
          hist_d[0] = q_lim;
          y_d       = 12'(hist_sum >> 2);
        end
        valid_d = 1'b1;
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (wd_expire) begin
      fault_d = 1'b1;
`ifdef SENSOR_FILTER_EN
      primed_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q <= S_IDLE;
      echo_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      y_q     <= Y_MID;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef SENSOR_FILTER_EN
      primed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      echo_q  <= echo_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef SENSOR_FILTER_EN
      primed_q <= primed_d;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
`endif
    end
  end

  assign paddle_y     = y_q;
  assign paddle_valid = valid_q;
  assign busy         = (state_q != S_IDLE);
  assign sensor_fault = fault_q;

endmodule
